// File: rtl/scan_capture.sv
// Serial scan frame capture: requests a frame from an upstream serializer,
// shifts it in LSB first and hands the word to a valid/ready consumer.
module scan_capture #(
    parameter int WIDTH = 19,
    parameter bit AUTO  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             scan_en,
    input  logic             scan_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clear_ovr
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             scan_en_reg;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic             data_valid_reg, data_valid_next;
    logic             overrun_reg, overrun_next;
    logic             frame_done;

    assign frame_done = (state_reg == SHIFT) && (cnt_reg == LAST_BIT);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start || AUTO) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                // upstream loads its frame on this edge; first bit arrives next
                state_next = SHIFT;
                cnt_next   = '0;
            end
            SHIFT: begin
                if (frame_done) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            scan_en_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            scan_en_reg <= (state_next != IDLE);
        end
    end

    // Each bit position takes scan_in only on its own slot; the completion
    // word is shift_next so the final bit lands without an extra cycle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign shift_next[gi] = ((state_reg == SHIFT) && (cnt_reg == CNT_W'(gi)))
                                    ? scan_in : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        overrun_next    = overrun_reg;
        if (frame_done) begin
            data_out_next   = shift_next;
            data_valid_next = 1'b1;
        end else if (data_valid_reg && data_ready) begin
            data_valid_next = 1'b0;
        end
        // a set on the same edge as clear_ovr must win
        if (frame_done && data_valid_reg && !data_ready) begin
            overrun_next = 1'b1;
        end else if (clear_ovr) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign scan_en    = scan_en_reg;
    assign busy       = scan_en_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_scan_capture.sv
// Randomised scoreboard bench for scan_capture with an upstream serializer
// model and an edge-counting reference of the frame/handshake behaviour.
module tb_scan_capture;
    localparam int WIDTH = 19;

    logic             clk = 1'b0;
    logic             rst;
    logic             start = 1'b0;
    logic             scan_in = 1'b0;
    logic             data_ready = 1'b0;
    logic             clear_ovr = 1'b0;
    logic             scan_en, busy, data_valid, overrun;
    logic [WIDTH-1:0] data_out;
    logic             a_scan_en, a_busy, a_valid, a_ovr;
    logic [WIDTH-1:0] a_data;

    int errors = 0;
    int checks = 0;
    int auto_frames = 0;

    logic [WIDTH-1:0] frame_src[$];
    logic [WIDTH-1:0] exp_q[$];

    bit               m_active = 1'b0;
    int               m_t = 0;
    logic [WIDTH-1:0] m_bits = '0;
    bit               exp_valid = 1'b0;
    bit               exp_ovr = 1'b0;
    logic [WIDTH-1:0] exp_data = '0;

    always #5 clk = ~clk;

    scan_capture #(.WIDTH(WIDTH), .AUTO(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .scan_en(scan_en), .scan_in(scan_in),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .overrun(overrun), .clear_ovr(clear_ovr)
    );

    scan_capture #(.WIDTH(WIDTH), .AUTO(1'b1)) dut_auto (
        .clk(clk), .rst(rst), .start(1'b0), .scan_en(a_scan_en), .scan_in(scan_in),
        .data_out(a_data), .data_valid(a_valid), .data_ready(1'b1),
        .busy(a_busy), .overrun(a_ovr), .clear_ovr(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream serializer: loads a frame on the first edge that sees scan_en
    // high, then presents one bit per clock, LSB first.
    initial begin : serializer
        logic [WIDTH-1:0] cur;
        int               idx;
        bit               loaded;
        logic             se_last;
        cur = '0; idx = 0; loaded = 1'b0; se_last = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                loaded  = 1'b0;
                se_last = 1'b0;
                scan_in = 1'b0;
                exp_q.delete();
            end else begin
                if (se_last && !loaded) begin
                    if (frame_src.size() > 0) cur = frame_src.pop_front();
                    else cur = WIDTH'($urandom);
                    loaded = 1'b1;
                    idx = 0;
                    scan_in = cur[0];
                    exp_q.push_back(cur);
                end else if (se_last && loaded) begin
                    idx++;
                    if (idx < WIDTH) scan_in = cur[idx];
                    else scan_in = 1'($urandom);
                end else begin
                    loaded = 1'b0;
                    scan_in = 1'($urandom);
                end
                se_last = scan_en;
            end
        end
    end

    // Reference: a request at edge E0 keeps the block busy until E0+WIDTH+1;
    // bit k is the serial input seen at edge E0+2+k.
    initial begin : model
        bit done, set_ovr;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0; m_t = 0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_data = '0;
            end else begin
                done = 1'b0;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        m_t = 0;
                    end
                end else begin
                    m_t++;
                    if (m_t >= 2 && m_t <= WIDTH + 1) m_bits[m_t-2] = scan_in;
                    if (m_t == WIDTH + 1) begin
                        done = 1'b1;
                        m_active = 1'b0;
                    end
                end
                set_ovr = done && exp_valid && !data_ready;
                if (done) begin
                    exp_valid = 1'b1;
                    exp_data = m_bits;
                end else if (exp_valid && data_ready) begin
                    exp_valid = 1'b0;
                end
                if (set_ovr) exp_ovr = 1'b1;
                else if (clear_ovr) exp_ovr = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic             busy_q;
        logic [WIDTH-1:0] f;
        busy_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_q = 1'b0;
            end else begin
                chk("busy", 32'(busy), 32'(m_active));
                chk("scan_en", 32'(scan_en), 32'(m_active));
                chk("data_valid", 32'(data_valid), 32'(exp_valid));
                chk("overrun", 32'(overrun), 32'(exp_ovr));
                chk("data_out", 32'(data_out), 32'(exp_data));
                if (busy_q && !busy) begin
                    if (exp_q.size() == 0) begin
                        chk("frame_queue_size", 32'(exp_q.size()), 32'd1);
                    end else begin
                        f = exp_q.pop_front();
                        $display("frame captured %05h expected %05h valid=%0b ovr=%0b",
                                 data_out, f, data_valid, overrun);
                        chk("frame", 32'(data_out), 32'(f));
                        chk("frame_valid", 32'(data_valid), 32'd1);
                    end
                end
                busy_q = busy;
            end
        end
    end

    initial begin : auto_mon
        int   hi, lo;
        logic prev;
        bit   seen_hi;
        hi = 0; lo = 0; prev = 1'b0; seen_hi = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi = 0; lo = 0; prev = 1'b0; seen_hi = 1'b0;
            end else begin
                if (a_scan_en && !prev) begin
                    if (seen_hi) chk("auto_gap", 32'(lo), 32'd1);
                    hi = 1;
                end else if (a_scan_en) begin
                    hi++;
                end else if (prev) begin
                    chk("auto_high", 32'(hi), 32'(WIDTH + 1));
                    auto_frames++;
                    seen_hi = 1'b1;
                    lo = 1;
                end else begin
                    lo++;
                end
                prev = a_scan_en;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_in_time", 32'(n < 100), 32'd1);
    endtask

    task automatic run_frame(input logic [WIDTH-1:0] f);
        frame_src.push_back(f);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle();
    endtask

    task automatic pulse_reset_check();
        #2 rst = 1'b1;
        #1;
        chk("rst_scan_en", 32'(scan_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_valid", 32'(data_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        data_ready = 1'b0;
        run_frame(19'h2A5A5);
        chk("first_frame", 32'(data_out), 32'h2A5A5);

        data_ready = 1'b1;
        run_frame(19'h00001);
        run_frame(19'h40000);
        chk("ready_no_overrun", 32'(overrun), 32'd0);
        @(negedge clk);

        data_ready = 1'b0;
        run_frame(19'h12345);
        run_frame(19'h6789A);
        chk("overwrite_data", 32'(data_out), 32'h6789A);
        chk("overwrite_overrun", 32'(overrun), 32'd1);
        clear_ovr = 1'b1;
        @(negedge clk); clear_ovr = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", 32'(overrun), 32'd0);

        // data_ready high only on the completion edge of a new frame
        frame_src.push_back(19'h0F0F0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (WIDTH) @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk); data_ready = 1'b0;
        wait_idle();
        chk("coincide_data", 32'(data_out), 32'h0F0F0);
        chk("coincide_valid", 32'(data_valid), 32'd1);
        chk("coincide_overrun", 32'(overrun), 32'd0);

        // abort a frame at E0+10
        frame_src.push_back(19'h7FFFF);
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (9) @(posedge clk);
        pulse_reset_check();
        repeat (5) @(negedge clk);
        chk("no_restart_after_rst", 32'(busy), 32'd0);
        run_frame(19'h55555);
        chk("post_rst_frame", 32'(data_out), 32'h55555);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start      = ($urandom_range(0, 7) == 0);
            data_ready = 1'($urandom);
            clear_ovr  = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        start = 1'b0; clear_ovr = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("auto_frames_seen", 32'(auto_frames >= 10), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
